// File: rtl/top_pkg.sv
// Shared definitions for the bidirectional gate passage counter.
// Sensor codes are {b1,b2}: b1 is the outer beam, b2 the inner beam.
package top_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IN1   = 3'd1,
    IN2   = 3'd2,
    IN3   = 3'd3,
    OUT1  = 3'd4,
    OUT2  = 3'd5,
    OUT3  = 3'd6,
    ABORT = 3'd7
  } state_t;

  localparam logic [1:0] S_CLR  = 2'b00;
  localparam logic [1:0] S_OUT  = 2'b10;
  localparam logic [1:0] S_BOTH = 2'b11;
  localparam logic [1:0] S_IN   = 2'b01;

endpackage

// File: rtl/top_sat_counter.sv
// Saturating up/down counter: holds at cnt_max on increment and at 0 on decrement.
// When inc and dec are both high the count is left unchanged.
module sat_counter #(
  parameter int CNT_W   = 3,
  parameter int CNT_MAX = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_MAX[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt < MAX_V)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/top.sv
// Board top of the gate passage counter: sensor decode FSM driving a saturating count.
// Define SYNC_EN to pass b1/b2 through 2-flop synchronizers (adds 2 cycles of latency).
module top
  import top_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int CNT_MAX = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             b1,
  input  logic             b2,
  output logic [CNT_W-1:0] leds
);

  logic [1:0] s;
  state_t     state;
  state_t     state_nxt;
  logic       inc;
  logic       dec;

`ifdef SYNC_EN
  logic [1:0] sync_q1;
  logic [1:0] sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 2'b00;
      sync_q2 <= 2'b00;
    end else begin
      sync_q1 <= {b1, b2};
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = {b1, b2};
`endif

  // Codes not listed for a state leave it unchanged.
  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    dec       = 1'b0;
    case (state)
      IDLE: begin
        if (s == S_OUT)       state_nxt = IN1;
        else if (s == S_IN)   state_nxt = OUT1;
        else if (s == S_BOTH) state_nxt = ABORT;
      end
      IN1: begin
        if (s == S_BOTH)      state_nxt = IN2;
        else if (s == S_CLR)  state_nxt = IDLE;
        else if (s == S_IN)   state_nxt = ABORT;
      end
      IN2: begin
        if (s == S_IN)        state_nxt = IN3;
        else if (s == S_OUT)  state_nxt = IN1;
      end
      IN3: begin
        if (s == S_CLR) begin
          state_nxt = IDLE;
          inc       = 1'b1;
        end else if (s == S_BOTH) state_nxt = IN2;
        else if (s == S_OUT)      state_nxt = ABORT;
      end
      OUT1: begin
        if (s == S_BOTH)      state_nxt = OUT2;
        else if (s == S_CLR)  state_nxt = IDLE;
        else if (s == S_OUT)  state_nxt = ABORT;
      end
      OUT2: begin
        if (s == S_OUT)       state_nxt = OUT3;
        else if (s == S_IN)   state_nxt = OUT1;
      end
      OUT3: begin
        if (s == S_CLR) begin
          state_nxt = IDLE;
          dec       = 1'b1;
        end else if (s == S_BOTH) state_nxt = OUT2;
        else if (s == S_IN)       state_nxt = ABORT;
      end
      ABORT: begin
        if (s == S_CLR)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  sat_counter #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_MAX)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .cnt   (leds)
  );

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the gate passage counter.
// The reference treats a passage as a walk around the ring 00-10-11-01 and counts full laps.
module tb_top;
  import top_pkg::*;

`ifdef SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       b1 = 1'b0;
  logic       b2 = 1'b0;
  logic [2:0] leds;

  int checks = 0;
  int failures = 0;

  // Reference model: signed ring displacement since leaving 00, plus abort flag.
  int         m_cnt;
  int         m_d;
  logic [1:0] m_prev;
  bit         m_abort;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  top #(.CNT_W(3), .CNT_MAX(7)) dut (
    .clk   (clk),
    .reset (reset),
    .b1    (b1),
    .b2    (b2),
    .leds  (leds)
  );

  function automatic int ring_idx(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring_code(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit model_idle();
    return !m_abort && (m_prev == 2'b00);
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_d     = 0;
    m_prev  = 2'b00;
    m_abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [1:0] code);
    int delta;
    if (code == m_prev) return;
    if (m_abort) begin
      m_prev = code;
      if (code == 2'b00) begin
        m_abort = 1'b0;
        m_d     = 0;
      end
      return;
    end
    if (code == 2'b00) begin
      // Both beams clearing at once from the middle is ignored.
      if (m_d == 2 || m_d == -2) return;
      if (m_d == 3 && m_cnt < 7) m_cnt = m_cnt + 1;
      if (m_d == -3 && m_cnt > 0) m_cnt = m_cnt - 1;
      m_d    = 0;
      m_prev = 2'b00;
      return;
    end
    delta = (ring_idx(code) - ring_idx(m_prev) + 4) % 4;
    if (delta == 1) m_d = m_d + 1;
    else if (delta == 3) m_d = m_d - 1;
    else m_abort = 1'b1;
    m_prev = code;
  endtask

  task automatic drive(input logic [1:0] code);
    @(negedge clk);
    {b1, b2} = code;
    repeat (1 + LAT) @(posedge clk);
    #1;
    model_sample(code);
    exp_q.push_back(m_cnt[2:0]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {b1, b2} = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (leds !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold leds=%0d expected=0", leds);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (leds !== 3'd0) begin
      failures++;
      $display("FAIL reset_release leds=%0d expected=0", leds);
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state state=%0d expected=%0d", dut.state, IDLE);
    end
  endtask

  task automatic test_entry();
    logic [1:0] seq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [2:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      exp = exp_q.pop_front();
      checks++;
      if (leds !== exp) begin
        failures++;
        $display("FAIL entry_step%0d leds=%0d expected=%0d", i, leds, exp);
      end
    end
    checks++;
    if (leds !== 3'd1) begin
      failures++;
      $display("FAIL entry_final leds=%0d expected=1", leds);
    end
  endtask

  task automatic test_exit();
    logic [1:0] seq [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00,
                             2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [2:0] exp;
    for (int i = 0; i < 10; i++) begin
      drive(seq[i]);
      exp = exp_q.pop_front();
      checks++;
      if (leds !== exp) begin
        failures++;
        $display("FAIL exit_step%0d leds=%0d expected=%0d", i, leds, exp);
      end
      if (i == 4) begin
        checks++;
        if (leds !== 3'd0) begin
          failures++;
          $display("FAIL exit_done leds=%0d expected=0", leds);
        end
      end
    end
  endtask

  task automatic test_pedestrian();
    logic [1:0] seq [8] = '{2'b00, 2'b10, 2'b01, 2'b00,
                            2'b00, 2'b01, 2'b10, 2'b00};
    logic [2:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(seq[i]);
      exp = exp_q.pop_front();
      checks++;
      if (leds !== exp) begin
        failures++;
        $display("FAIL pedestrian_step%0d leds=%0d expected=%0d", i, leds, exp);
      end
    end
    checks++;
    if (leds !== 3'd1 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL pedestrian_final leds=%0d state=%0d expected leds=1 state=%0d",
               leds, dut.state, IDLE);
    end
  endtask

  task automatic run_passage(input bit entry, input string tag);
    logic [1:0] ent [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ext [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [2:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(entry ? ent[i] : ext[i]);
      exp = exp_q.pop_front();
      checks++;
      if (leds !== exp) begin
        failures++;
        $display("FAIL %s_step%0d leds=%0d expected=%0d", tag, i, leds, exp);
      end
    end
  endtask

  task automatic test_saturation();
    run_passage(1'b0, "sat_to_zero");
    for (int k = 0; k < 8; k++) run_passage(1'b1, "sat_up");
    checks++;
    if (leds !== 3'd7) begin
      failures++;
      $display("FAIL sat_ceiling leds=%0d expected=7", leds);
    end
    run_passage(1'b0, "sat_down");
    checks++;
    if (leds !== 3'd6) begin
      failures++;
      $display("FAIL sat_one_exit leds=%0d expected=6", leds);
    end
    for (int k = 0; k < 6; k++) run_passage(1'b0, "sat_drain");
    run_passage(1'b0, "sat_floor");
    checks++;
    if (leds !== 3'd0) begin
      failures++;
      $display("FAIL sat_floor leds=%0d expected=0", leds);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    for (int k = 0; k < 3; k++) run_passage(1'b1, "mid_fill");
    drive(2'b10);
    drive(2'b11);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    checks++;
    if (leds !== 3'd3 || dut.state !== IN2) begin
      failures++;
      $display("FAIL mid_setup leds=%0d state=%0d expected leds=3 state=%0d",
               leds, dut.state, IN2);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (leds !== 3'd0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL mid_async leds=%0d state=%0d expected leds=0 state=%0d",
               leds, dut.state, IDLE);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b11);
    drive(2'b01);
    drive(2'b00);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (exp !== 3'd0 || leds !== 3'd0) begin
        failures++;
        $display("FAIL mid_after_release leds=%0d expected=0", leds);
      end
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL mid_end_state state=%0d expected=%0d", dut.state, IDLE);
    end
  endtask

  task automatic test_random();
    logic [1:0] cur;
    logic [2:0] exp;
    int r;
    for (int i = 0; i < 400; i++) begin
      cur = {b1, b2};
      r = $urandom_range(0, 9);
      if (r < 5)      cur = ring_code(ring_idx(cur) + 1);
      else if (r < 8) cur = ring_code(ring_idx(cur) + 3);
      else if (r < 9) cur = 2'($urandom_range(0, 3));
      drive(cur);
      exp = exp_q.pop_front();
      checks++;
      if (leds !== exp) begin
        failures++;
        $display("FAIL random_leds step=%0d in=%b leds=%0d expected=%0d", i, cur, leds, exp);
      end
      checks++;
      if ((dut.state == IDLE) !== model_idle()) begin
        failures++;
        $display("FAIL random_idle step=%0d state=%0d expected_idle=%0d",
                 i, dut.state, model_idle());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_entry();
    test_exit();
    test_pedestrian();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Bidirectional passage counter for a single-lane gate, such as a car-park entrance.
- Two sensors, b1 (outer) and b2 (inner), are decoded by a quadrature-style FSM to tell entries from exits.
- Pedestrian-like or invalid patterns are rejected.
- The occupancy count is driven to a 3-bit LED bank. This is the board top-level of the counter design.

Parameters:
- CNT_W, 3, width of the occupancy counter and of leds
- CNT_MAX, 7, saturation ceiling of the counter; must be at most 2**CNT_W-1

Ports:
- clk  input  1  system clock; every register is on the rising edge
- reset  input  1  asynchronous, active-low reset
- b1  input  1  outer sensor, 1 = beam blocked; asynchronous to clk
- b2  input  1  inner sensor, 1 = beam blocked; asynchronous to clk
- leds  output  CNT_W  current occupancy count, binary, registered

Behaviour:
- Reset (reset=0), asserted asynchronously:
  - FSM goes to IDLE.
  - Counter and leds go to 0.
  - Synchronizer flops go to 0.
  - This also applies when reset is asserted mid-sequence: the partial sequence is discarded.
- Input sample s = {b1,b2}, taken once per rising edge after the optional synchronizer. Every transition below is on a rising edge.
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ABORT. Unlisted input values hold the current state.
- IDLE:
  - s=10 -> IN1.
  - s=01 -> OUT1.
  - s=11 -> ABORT.
  - s=00 -> stay.
- Entry path:
  - IN1: 11 -> IN2; 00 -> IDLE (backed out); 01 -> ABORT (pedestrian pattern).
  - IN2: 01 -> IN3; 10 -> IN1 (reversal).
  - IN3: 00 -> IDLE with count +1; 11 -> IN2; 10 -> ABORT.
- Exit path (mirror of entry):
  - OUT1: 11 -> OUT2; 00 -> IDLE; 10 -> ABORT.
  - OUT2: 10 -> OUT3; 01 -> OUT1.
  - OUT3: 00 -> IDLE with count -1; 11 -> OUT2; 01 -> ABORT.
- ABORT: stay until s=00, then -> IDLE. No count change.
- Counter:
  - Updated in the same edge as the IN3->IDLE or OUT3->IDLE transition.
  - leds is the counter register itself, so the new value is visible right after that edge.
  - Saturating: an increment at CNT_MAX holds CNT_MAX; a decrement at 0 holds 0.
  - Never incremented and decremented in the same cycle.
- Latency: inputs are held at least one clock period. The count updates on the first edge at which the final 00 is sampled, plus the synchronizer depth when that is compiled in.

Optional Feature:
- Macro SYNC_EN.
- Defined: b1 and b2 each pass through a 2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles of latency. Sensor steps must then be held at least 1 clock period.
- Undefined: the FSM samples b1 and b2 directly, with no added latency.
- FSM and counter behaviour are otherwise identical in both builds.

Decomposition:
- Package top_pkg holds:
  - the state enum (IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ABORT);
  - localparams for the sensor codes S_CLR=00, S_OUT=10, S_BOTH=11, S_IN=01.
- One sub-module, sat_counter: saturating up/down counter with inc, dec and async active-low reset, parameterized by CNT_W and CNT_MAX.
- FSM and synchronizer stay inline in top.

Test Plan:
- Reset low for 5 clocks, then release -> leds=0, FSM in IDLE.
- Entry 00,10,11,01,00 -> leds 0->1.
- Exit 00,01,11,10,00 -> leds 1->0. A following entry -> leds=1.
- Pedestrian 00,10,01,00, then 00,01,10,00 -> leds stays 1 and FSM ends in IDLE.
- 8 entries from 0 -> leds saturates at 7. Then 1 exit -> 6. Exit from 0 -> stays 0.
- Reset asserted while in IN2 with leds=3 -> leds=0 immediately (asynchronous). Remaining 01,00 after release -> no count change.
